// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the counter sequencer slice:
//   - seq_state_t : 3-bit sequencer state encoding (SEQ_IDLE .. SEQ_FINISH)
//   - LED_WIDTH_DEFAULT      : default width of each stage LED bus
//   - TIMEOUT_CYCLES_DEFAULT : default WAIT watchdog limit (used with SEQ_TIMEOUT_EN)
package counter_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_LAUNCH  = 3'd1,
        SEQ_WAIT    = 3'd2,
        SEQ_ADVANCE = 3'd3,
        SEQ_FINISH  = 3'd4
    } seq_state_t;

    localparam int LED_WIDTH_DEFAULT      = 5;
    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog
//   Down-counting watchdog for the sequencer WAIT state. The count is loaded
//   with TIMEOUT_CYCLES-1 on clear and decrements on every enabled cycle;
//   expired is raised on the TIMEOUT_CYCLES-th consecutive enabled cycle
//   after a clear (terminal count reached while enabled).
//   Only instantiated when SEQ_TIMEOUT_EN is defined.
// Ports
//   clock   in  system clock
//   reset   in  synchronous, active-high
//   clear   in  reload the counter
//   enable  in  count this cycle
//   expired out terminal count reached while enabled
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Round-robin sequencer for NUM_STAGES counter stages. Each stage is
//   launched with a one-cycle stage_go pulse; the sequencer then waits for
//   that stage's one-cycle stage_next pulse before moving to the next stage.
//   After LOOPS full passes (0 = forever) it pulses seq_done and returns idle.
//   The active stage's LED bus is registered onto led_out every cycle.
//   Optional build macro SEQ_TIMEOUT_EN adds a WAIT watchdog and the sticky
//   timeout_err output.
// Ports
//   clock, reset  system clock, synchronous active-high reset
//   start, stop   start (accepted only in idle) / abort (any busy state)
//   stage_next    per-stage completion pulses
//   stage_led     packed LED buses, stage i at [i*LED_WIDTH +: LED_WIDTH]
//   stage_go      one-hot launch pulse
//   stage_clear   abort pulse returning all stages to idle
//   led_out       registered LED bus of the active stage
//   active_stage  current stage index
//   busy          high outside idle
//   seq_done      one-cycle pulse after the final pass
//   loop_count    completed passes (wraps)
//   timeout_err   sticky watchdog error (SEQ_TIMEOUT_EN only)
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int NUM_STAGES     = 2,
    parameter int LED_WIDTH      = LED_WIDTH_DEFAULT,
    parameter int LOOPS          = 1,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    input  logic [NUM_STAGES-1:0]           stage_next,
    input  logic [NUM_STAGES*LED_WIDTH-1:0] stage_led,
    output logic [NUM_STAGES-1:0]           stage_go,
    output logic                            stage_clear,
    output logic [LED_WIDTH-1:0]            led_out,
    output logic [2:0]                      active_stage,
    output logic                            busy,
    output logic                            seq_done,
    output logic [7:0]                      loop_count
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic                            timeout_err
`endif
);

    localparam logic [2:0] LAST_STAGE  = 3'(NUM_STAGES - 1);
    localparam logic [7:0] LOOP_TARGET = 8'(LOOPS);

    seq_state_t           state;
    seq_state_t           state_next;
    logic [2:0]           stage_idx;
    logic [2:0]           stage_idx_next;
    logic [7:0]           loops;
    logic [7:0]           loops_next;
    logic                 sel_next;
    logic [LED_WIDTH-1:0] sel_led;
    logic                 start_ok;
    logic                 wd_expired;

    // Mux by compare rather than direct indexing so any NUM_STAGES works
    // with the fixed 3-bit stage index.
    always_comb begin
        sel_next = 1'b0;
        sel_led  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_idx == 3'(i)) begin
                sel_next = stage_next[i];
                sel_led  = stage_led[i*LED_WIDTH +: LED_WIDTH];
            end
        end
    end

    assign start_ok = (state == SEQ_IDLE) && start && !stop;

`ifdef SEQ_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;
    logic timeout_hit;

    // WAIT is only ever entered from LAUNCH, so reloading there restarts
    // the watchdog on every WAIT entry.
    assign wd_clear  = (state == SEQ_LAUNCH);
    assign wd_enable = (state == SEQ_WAIT);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // stop and a real completion both take priority over the timeout.
    assign timeout_hit = (state == SEQ_WAIT) && !stop && !sel_next && wd_expired;

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (start_ok) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        stage_idx_next = stage_idx;
        loops_next     = loops;
        stage_go       = '0;
        stage_clear    = 1'b0;
        seq_done       = 1'b0;

        if (state == SEQ_IDLE) begin
            if (start_ok) begin
                state_next     = SEQ_LAUNCH;
                stage_idx_next = '0;
                loops_next     = '0;
            end
        end else if (stop) begin
            // Abort beats everything else, including a launch this cycle.
            state_next  = SEQ_IDLE;
            stage_clear = 1'b1;
        end else begin
            case (state)
                SEQ_LAUNCH: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        stage_go[i] = (stage_idx == 3'(i));
                    end
                    state_next = SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (sel_next) begin
                        state_next = SEQ_ADVANCE;
                    end else if (wd_expired) begin
                        state_next  = SEQ_IDLE;
                        stage_clear = 1'b1;
                    end
                end
                SEQ_ADVANCE: begin
                    if (stage_idx == LAST_STAGE) begin
                        loops_next     = loops + 8'd1;
                        stage_idx_next = '0;
                        if ((LOOPS != 0) && (loops_next == LOOP_TARGET)) begin
                            state_next = SEQ_FINISH;
                        end else begin
                            state_next = SEQ_LAUNCH;
                        end
                    end else begin
                        stage_idx_next = stage_idx + 3'd1;
                        state_next     = SEQ_LAUNCH;
                    end
                end
                SEQ_FINISH: begin
                    seq_done   = 1'b1;
                    state_next = SEQ_IDLE;
                end
                default: begin
                    state_next = SEQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SEQ_IDLE;
            stage_idx <= '0;
            loops     <= '0;
            led_out   <= '0;
        end else begin
            state     <= state_next;
            stage_idx <= stage_idx_next;
            loops     <= loops_next;
            led_out   <= sel_led;
        end
    end

    assign active_stage = stage_idx;
    assign loop_count   = loops;
    assign busy         = (state != SEQ_IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Two sequencer instances (LOOPS=1 and LOOPS=0, two stages each) driven
//   by directed steps with randomized stage response delays. Expected
//   timing is derived from the handshake rules: start seen in cycle s gives
//   go in s+1; next seen in cycle n gives the following go (or seq_done) in
//   n+2; busy drops the cycle after seq_done or after a stop.
//   Define SEQ_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_counter_sequencer;

    localparam int N  = 2;
    localparam int LW = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int free_done_seen = 0;

    logic                reset;
    logic                start_v    [2];
    logic                stop_v     [2];
    logic [N-1:0]        next_v     [2];
    logic [N*LW-1:0]     led_in_v   [2];
    logic [N-1:0]        go_v       [2];
    logic                clear_v    [2];
    logic [LW-1:0]       led_v      [2];
    logic [2:0]          act_v      [2];
    logic                busy_v     [2];
    logic                done_v     [2];
    logic [7:0]          loops_v    [2];
`ifdef SEQ_TIMEOUT_EN
    logic                terr_v     [2];
`endif

    counter_sequencer #(
        .NUM_STAGES(N), .LED_WIDTH(LW), .LOOPS(1), .TIMEOUT_CYCLES(16)
    ) u_dut_once (
        .clock(clock), .reset(reset), .start(start_v[0]), .stop(stop_v[0]),
        .stage_next(next_v[0]), .stage_led(led_in_v[0]), .stage_go(go_v[0]),
        .stage_clear(clear_v[0]), .led_out(led_v[0]), .active_stage(act_v[0]),
        .busy(busy_v[0]), .seq_done(done_v[0]), .loop_count(loops_v[0])
`ifdef SEQ_TIMEOUT_EN
        , .timeout_err(terr_v[0])
`endif
    );

    counter_sequencer #(
        .NUM_STAGES(N), .LED_WIDTH(LW), .LOOPS(0), .TIMEOUT_CYCLES(16)
    ) u_dut_free (
        .clock(clock), .reset(reset), .start(start_v[1]), .stop(stop_v[1]),
        .stage_next(next_v[1]), .stage_led(led_in_v[1]), .stage_go(go_v[1]),
        .stage_clear(clear_v[1]), .led_out(led_v[1]), .active_stage(act_v[1]),
        .busy(busy_v[1]), .seq_done(done_v[1]), .loop_count(loops_v[1])
`ifdef SEQ_TIMEOUT_EN
        , .timeout_err(terr_v[1])
`endif
    );

    always @(posedge clock) if (done_v[1]) free_done_seen++;

    initial begin
        #500000;
        $display("FAIL global_time_limit: run did not reach its summary");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] slice(input logic [N*LW-1:0] bus, input int i);
        return bus[i*LW +: LW];
    endfunction

    function automatic int krand();
        return int'($urandom_range(2, 9));
    endfunction

    task automatic check_reset(input bit d);
        check("rst_go",     32'(go_v[d]),    0);
        check("rst_clear",  32'(clear_v[d]), 0);
        check("rst_led",    32'(led_v[d]),   0);
        check("rst_active", 32'(act_v[d]),   0);
        check("rst_busy",   32'(busy_v[d]),  0);
        check("rst_done",   32'(done_v[d]),  0);
        check("rst_loops",  32'(loops_v[d]), 0);
`ifdef SEQ_TIMEOUT_EN
        check("rst_terr",   32'(terr_v[d]),  0);
`endif
    endtask

    // Pulse start for one cycle; returns at the cycle the first go is due.
    task automatic start_seq(input bit d);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    // Entered in the cycle stage i's go is due; the stage answers k cycles
    // after go. Returns in the cycle the following go / seq_done is due.
    task automatic serve_stage(input bit d, input int i, input int k, input int exp_loops);
        check($sformatf("go_stage%0d", i), 32'(go_v[d]), 32'(1 << i));
        check("active_stage", 32'(act_v[d]), 32'(i));
        check("loop_count", 32'(loops_v[d]), 32'(exp_loops));
        for (int c = 1; c < k; c++) begin
            tick();
            check("go_quiet", 32'(go_v[d]), 0);
            check("led_active", 32'(led_v[d]), 32'(slice(led_in_v[d], i)));
        end
        tick();
        next_v[d] = N'(1 << i);
        tick();
        next_v[d] = '0;
        check("go_gap", 32'(go_v[d]), 0);
        check("busy_advance", 32'(busy_v[d]), 1);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d]  = 1'b0;
            stop_v[d]   = 1'b0;
            next_v[d]   = '0;
            led_in_v[d] = 10'($urandom);
        end
        repeat (3) tick();
        check_reset(1'b0);
        check_reset(1'b1);
        reset = 1'b0;
        tick();

        // Single pass (LOOPS=1); first run uses the {9, 22} LED pattern.
        for (int it = 0; it < 4; it++) begin
            led_in_v[0] = (it == 0) ? {5'd9, 5'd22} : 10'($urandom);
            repeat (2) tick();
            start_seq(1'b0);
            serve_stage(1'b0, 0, krand(), 0);
            serve_stage(1'b0, 1, krand(), 0);
            check("seq_done", 32'(done_v[0]), 1);
            check("finish_go", 32'(go_v[0]), 0);
            check("finish_loops", 32'(loops_v[0]), 1);
            check("finish_busy", 32'(busy_v[0]), 1);
            check("led_finish", 32'(led_v[0]), 32'(slice(led_in_v[0], 1)));
            tick();
            check("idle_busy", 32'(busy_v[0]), 0);
            check("idle_done", 32'(done_v[0]), 0);
            check("idle_active", 32'(act_v[0]), 0);
            check("idle_loops", 32'(loops_v[0]), 1);
            check("led_idle", 32'(led_v[0]), 32'(slice(led_in_v[0], 0)));
        end

        // Free-running (LOOPS=0): three passes, then stop in WAIT.
        led_in_v[1] = 10'($urandom);
        tick();
        start_seq(1'b1);
        for (int p = 0; p < 3; p++) begin
            serve_stage(1'b1, 0, krand(), p);
            serve_stage(1'b1, 1, krand(), p);
            check("free_no_done", 32'(done_v[1]), 0);
        end
        check("free_go_pass4", 32'(go_v[1]), 1);
        check("free_loops3", 32'(loops_v[1]), 3);
        tick();
        stop_v[1] = 1'b1;
        #1;
        check("stop_clear", 32'(clear_v[1]), 1);
        check("stop_busy_still", 32'(busy_v[1]), 1);
        tick();
        stop_v[1] = 1'b0;
        #1;
        check("stop_busy_low", 32'(busy_v[1]), 0);
        check("stop_clear_once", 32'(clear_v[1]), 0);
        check("stop_loops_hold", 32'(loops_v[1]), 3);
        check("stop_no_done", 32'(done_v[1]), 0);
        tick();
        check("free_done_total", 32'(free_done_seen), 0);

        // stop in the same cycle as stage1 next: stop wins.
        repeat (2) tick();
        start_seq(1'b0);
        serve_stage(1'b0, 0, krand(), 0);
        check("s3_go1", 32'(go_v[0]), 2);
        repeat (3) tick();
        next_v[0] = 2'b10;
        stop_v[0] = 1'b1;
        #1;
        check("s3_clear", 32'(clear_v[0]), 1);
        tick();
        next_v[0] = '0;
        stop_v[0] = 1'b0;
        check("s3_busy", 32'(busy_v[0]), 0);
        check("s3_done", 32'(done_v[0]), 0);
        check("s3_loops", 32'(loops_v[0]), 0);
        check("s3_active_hold", 32'(act_v[0]), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("s3_quiet_go", 32'(go_v[0]), 0);
            check("s3_quiet_done", 32'(done_v[0]), 0);
        end

        // Wrong-stage next and start while busy are both ignored.
        tick();
        start_seq(1'b0);
        check("s4_go0", 32'(go_v[0]), 1);
        repeat (2) tick();
        next_v[0]  = 2'b10;
        start_v[0] = 1'b1;
        tick();
        next_v[0]  = '0;
        start_v[0] = 1'b0;
        check("s4_busy", 32'(busy_v[0]), 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("s4_no_go", 32'(go_v[0]), 0);
            check("s4_active", 32'(act_v[0]), 0);
        end
        next_v[0] = 2'b01;
        tick();
        next_v[0] = '0;
        tick();
        serve_stage(1'b0, 1, krand(), 0);
        check("s4_done", 32'(done_v[0]), 1);
        tick();

        // start together with stop in IDLE: stay idle.
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        #1;
        check("ss_no_clear", 32'(clear_v[0]), 0);
        tick();
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        check("ss_idle", 32'(busy_v[0]), 0);
        check("ss_no_go", 32'(go_v[0]), 0);

        // Reset in the middle of a WAIT.
        tick();
        start_seq(1'b0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("rst_mid_no_clear", 32'(clear_v[0]), 0);
        tick();
        reset = 1'b0;
        check_reset(1'b0);
        tick();

`ifdef SEQ_TIMEOUT_EN
        // Stage 0 never answers; 16 WAIT cycles then abort.
        tick();
        start_seq(1'b0);
        check("wd_go", 32'(go_v[0]), 1);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("wd_quiet", 32'(clear_v[0]), 0);
        end
        tick();
        check("wd_clear", 32'(clear_v[0]), 1);
        check("wd_busy", 32'(busy_v[0]), 1);
        tick();
        check("wd_idle", 32'(busy_v[0]), 0);
        check("wd_terr", 32'(terr_v[0]), 1);
        check("wd_no_done", 32'(done_v[0]), 0);
        tick();
        check("wd_terr_sticky", 32'(terr_v[0]), 1);
        start_seq(1'b0);
        check("wd_terr_cleared", 32'(terr_v[0]), 0);
        check("wd_restart_go", 32'(go_v[0]), 1);
        stop_v[0] = 1'b1;
        tick();
        stop_v[0] = 1'b0;
        check("wd_stop_idle", 32'(busy_v[0]), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
